// File: rtl/cpu_pkg.sv
// Shared decode constants and ALU operation encoding for the single-cycle core.
package cpu_pkg;

  // Major opcodes of the supported RV32I subset
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct3 values for ALU, memory, branch and jump instructions
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JALR = 3'b000;

  // funct7 values: base encoding and the alternate (sub / sra) encoding
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  // Map funct3 plus the alternate-encoding flag onto an ALU operation
  function automatic alu_op_t aluOpFor(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// 32-bit integer ALU; zero flag drives the BEQ/BNE decision.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y,
  output logic        zero
);

  // Select the arithmetic/logic result for the requested operation
  always_comb begin
    y = 32'd0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {31'd0, (a < b)};
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
      default:  y = 32'd0;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I-subset core: fetch, decode, execute and retire each clock.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] readData,
  output logic [31:0] result,
  output logic [31:0] instrAddr,
  output logic [31:0] dataAddr,
  output logic [31:0] writeData,
  output logic        we
);

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wbSel_t;

  logic [31:0] pc_r;
  logic [31:0] regFile_r [0:31];

  logic [6:0]  opcode_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic        f7Base_s, f7Alt_s;
  logic [31:0] rs1Val_s, rs2Val_s;
  logic [31:0] immI_s, immS_s, immB_s, immU_s, immJ_s;
  logic [31:0] aluA_s, aluB_s, aluY_s;
  logic        aluZero_s;
  alu_op_t     aluOp_s;
  logic        regWe_s, memWe_s;
  logic        isBeq_s, isBne_s, isJal_s, isJalr_s;
  wbSel_t      wbSel_s;
  logic [31:0] pcPlus4_s, nextPc_s, wbData_s;

  assign opcode_s = instr[6:0];
  assign rd_s     = instr[11:7];
  assign funct3_s = instr[14:12];
  assign rs1_s    = instr[19:15];
  assign rs2_s    = instr[24:20];
  assign funct7_s = instr[31:25];
  assign f7Base_s = (funct7_s == F7_BASE);
  assign f7Alt_s  = (funct7_s == F7_ALT);

  // x0 is hardwired to zero on read; its storage entry is never written
  assign rs1Val_s = (rs1_s == 5'd0) ? 32'd0 : regFile_r[rs1_s];
  assign rs2Val_s = (rs2_s == 5'd0) ? 32'd0 : regFile_r[rs2_s];

  // Sign-extended immediates for each instruction format
  assign immI_s = {{20{instr[31]}}, instr[31:20]};
  assign immS_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immU_s = {instr[31:12], 12'd0};
  assign immJ_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Decode opcode/funct fields into ALU operands, writeback and control flow
  always_comb begin
    aluA_s   = rs1Val_s;
    aluB_s   = rs2Val_s;
    aluOp_s  = ALU_ADD;
    regWe_s  = 1'b0;
    memWe_s  = 1'b0;
    wbSel_s  = WB_ALU;
    isBeq_s  = 1'b0;
    isBne_s  = 1'b0;
    isJal_s  = 1'b0;
    isJalr_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        aluOp_s = aluOpFor(funct3_s, f7Alt_s);
        regWe_s = f7Base_s | (f7Alt_s & ((funct3_s == F3_ADD) | (funct3_s == F3_SR)));
      end
      OP_IALU: begin
        aluB_s  = immI_s;
        // bit 30 only selects sra for shifts; for addi it is an immediate bit
        aluOp_s = aluOpFor(funct3_s, instr[30] & (funct3_s == F3_SR));
        case (funct3_s)
          F3_SLL:  regWe_s = f7Base_s;
          F3_SR:   regWe_s = f7Base_s | f7Alt_s;
          default: regWe_s = 1'b1;
        endcase
      end
      OP_LW: begin
        aluB_s  = immI_s;
        regWe_s = (funct3_s == F3_WORD);
        wbSel_s = WB_MEM;
      end
      OP_SW: begin
        aluB_s  = immS_s;
        memWe_s = (funct3_s == F3_WORD);
      end
      OP_BRANCH: begin
        aluOp_s = ALU_SUB;
        isBeq_s = (funct3_s == F3_BEQ);
        isBne_s = (funct3_s == F3_BNE);
      end
      OP_JAL: begin
        aluA_s  = 32'd0;
        aluB_s  = immJ_s;
        regWe_s = 1'b1;
        wbSel_s = WB_LINK;
        isJal_s = 1'b1;
      end
      OP_JALR: begin
        aluB_s   = immI_s;
        regWe_s  = (funct3_s == F3_JALR);
        wbSel_s  = WB_LINK;
        isJalr_s = (funct3_s == F3_JALR);
      end
      OP_LUI: begin
        aluA_s  = 32'd0;
        aluB_s  = immU_s;
        regWe_s = 1'b1;
      end
      default: begin
        regWe_s = 1'b0;
        memWe_s = 1'b0;
      end
    endcase
  end

  cpu_alu alu (
    .a    (aluA_s),
    .b    (aluB_s),
    .op   (aluOp_s),
    .y    (aluY_s),
    .zero (aluZero_s)
  );

  // Next-PC selection: jumps, taken branches, otherwise sequential
  always_comb begin
    pcPlus4_s = pc_r + 32'd4;
    if (isJal_s) begin
      nextPc_s = pc_r + immJ_s;
    end else if (isJalr_s) begin
      nextPc_s = {aluY_s[31:1], 1'b0};
    end else if ((isBeq_s & aluZero_s) | (isBne_s & ~aluZero_s)) begin
      nextPc_s = pc_r + immB_s;
    end else begin
      nextPc_s = pcPlus4_s;
    end
  end

  // Writeback source: ALU result, load data or return address
  always_comb begin
    case (wbSel_s)
      WB_MEM:  wbData_s = readData;
      WB_LINK: wbData_s = pcPlus4_s;
      default: wbData_s = aluY_s;
    endcase
  end

  // Program counter; reset takes effect immediately and holds the PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= nextPc_s;
    end
  end

  // Register file write port; contents survive reset by design
  always_ff @(posedge clk) begin
    if (!reset && regWe_s && (rd_s != 5'd0)) begin
      regFile_r[rd_s] <= wbData_s;
    end
  end

  assign instrAddr = pc_r;
  assign result    = aluY_s;
  assign dataAddr  = aluY_s;
  assign writeData = rs2Val_s;
  // Store strobe is suppressed while reset is asserted
  assign we        = reset ? 1'b0 : memWe_s;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed scenarios plus random instruction streams
// checked against an architectural model of the register file and PC.
module tb_cpu;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, reset;
  logic [31:0] instr, readData, result, instrAddr, dataAddr, writeData;
  logic        we;

  cpu #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .readData  (readData),
    .result    (result),
    .instrAddr (instrAddr),
    .dataAddr  (dataAddr),
    .writeData (writeData),
    .we        (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_JALR, K_LUI, K_BADOP, K_BADF7
  } kind_t;
  localparam int NKINDS = 28;

  logic [31:0] mReg [32];
  bit          mKnown [32];
  logic [31:0] mPc;
  logic [31:0] lastRes;
  int          errCount = 0;
  int          checkCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      errCount++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] f3Of(input kind_t k);
    case (k)
      K_SLL, K_SLLI, K_BNE:           return 3'b001;
      K_SLT, K_SLTI:                  return 3'b010;
      K_SLTU, K_SLTIU:                return 3'b011;
      K_XOR, K_XORI:                  return 3'b100;
      K_SRL, K_SRA, K_SRLI, K_SRAI:   return 3'b101;
      K_OR, K_ORI:                    return 3'b110;
      K_AND, K_ANDI:                  return 3'b111;
      default:                        return 3'b000;
    endcase
  endfunction

  // Architectural meaning of each ALU-class instruction
  function automatic logic [31:0] semantic(input kind_t k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      K_ADD, K_ADDI:   return a + b;
      K_SUB:           return a - b;
      K_SLL, K_SLLI:   return a << b[4:0];
      K_SLT, K_SLTI:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU, K_SLTIU: return (a < b) ? 32'd1 : 32'd0;
      K_XOR, K_XORI:   return a ^ b;
      K_SRL, K_SRLI:   return a >> b[4:0];
      K_SRA, K_SRAI:   return $unsigned($signed(a) >>> b[4:0]);
      K_OR, K_ORI:     return a | b;
      K_AND, K_ANDI:   return a & b;
      default:         return 32'd0;
    endcase
  endfunction

  function automatic int pickKnown();
    for (int t = 0; t < 8; t++) begin
      int r;
      r = $urandom_range(31, 0);
      if (mKnown[r]) return r;
    end
    return 0;
  endfunction

  // Encode one instruction, drive it, check the outputs, then retire it in the model
  task automatic exec(input kind_t k, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input logic [31:0] rdata);
    logic [31:0] ins, a, b, sx, expRes, expNext, wbVal;
    logic [6:0]  f7;
    logic [4:0]  rdF, rs1F, rs2F;
    bit          doWb, expWe, chkRes;
    int          wdReg;
    rdF = 5'(rd); rs1F = 5'(rs1); rs2F = 5'(rs2);
    a = mReg[rs1]; b = mReg[rs2];
    sx = {{20{imm[11]}}, imm[11:0]};
    doWb = 1'b1; expWe = 1'b0; chkRes = 1'b1;
    expNext = mPc + 32'd4; expRes = 32'd0; wbVal = 32'd0;
    f7 = (k == K_SUB || k == K_SRA || k == K_SRAI) ? 7'b0100000 : 7'b0000000;
    case (k)
      K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND: begin
        ins = {f7, rs2F, rs1F, f3Of(k), rdF, 7'b0110011};
        expRes = semantic(k, a, b); wbVal = expRes;
      end
      K_SLLI, K_SRLI, K_SRAI: begin
        ins = {f7, imm[4:0], rs1F, f3Of(k), rdF, 7'b0010011};
        expRes = semantic(k, a, {27'd0, imm[4:0]}); wbVal = expRes;
      end
      K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI: begin
        ins = {imm[11:0], rs1F, f3Of(k), rdF, 7'b0010011};
        expRes = semantic(k, a, sx); wbVal = expRes;
      end
      K_LW: begin
        ins = {imm[11:0], rs1F, 3'b010, rdF, 7'b0000011};
        expRes = a + sx; wbVal = rdata;
      end
      K_SW: begin
        ins = {imm[11:5], rs2F, rs1F, 3'b010, imm[4:0], 7'b0100011};
        expRes = a + sx; doWb = 1'b0; expWe = 1'b1;
      end
      K_BEQ, K_BNE: begin
        ins = {imm[12], imm[10:5], rs2F, rs1F, f3Of(k), imm[4:1], imm[11], 7'b1100011};
        expRes = a - b; doWb = 1'b0;
        if ((k == K_BEQ) ? (a == b) : (a != b))
          expNext = mPc + {{19{imm[12]}}, imm[12:1], 1'b0};
      end
      K_JAL: begin
        ins = {imm[20], imm[10:1], imm[11], imm[19:12], rdF, 7'b1101111};
        expRes = {{11{imm[20]}}, imm[20:1], 1'b0};
        expNext = mPc + expRes; wbVal = mPc + 32'd4;
      end
      K_JALR: begin
        ins = {imm[11:0], rs1F, 3'b000, rdF, 7'b1100111};
        expRes = a + sx; expNext = expRes & 32'hFFFF_FFFE; wbVal = mPc + 32'd4;
      end
      K_LUI: begin
        ins = {imm[19:0], rdF, 7'b0110111};
        expRes = {imm[19:0], 12'h000}; wbVal = expRes;
      end
      K_BADOP: begin
        ins = {imm[24:0], 7'b0001111}; doWb = 1'b0; chkRes = 1'b0;
      end
      default: begin
        ins = {7'b0000001, rs2F, rs1F, 3'b000, rdF, 7'b0110011}; doWb = 1'b0; chkRes = 1'b0;
      end
    endcase
    instr = ins; readData = rdata;
    #1;
    checkVal($sformatf("%s instrAddr", k.name()), instrAddr, mPc);
    checkVal($sformatf("%s we", k.name()), {31'd0, we}, {31'd0, expWe});
    if (chkRes) begin
      checkVal($sformatf("%s result", k.name()), result, expRes);
      checkVal($sformatf("%s dataAddr", k.name()), dataAddr, expRes);
    end
    wdReg = int'(ins[24:20]);
    if (mKnown[wdReg]) checkVal($sformatf("%s writeData", k.name()), writeData, mReg[wdReg]);
    lastRes = result;
    @(negedge clk);
    if (doWb && rd != 0) begin
      mReg[rd] = wbVal;
      mKnown[rd] = 1'b1;
    end
    mPc = expNext;
  endtask

  task automatic randomRun(input int count);
    for (int n = 0; n < count; n++) begin
      kind_t k;
      int    r1, r2;
      k  = kind_t'($urandom_range(NKINDS - 1, 0));
      r1 = pickKnown();
      r2 = ($urandom_range(1, 0) == 1) ? r1 : pickKnown();
      exec(k, $urandom_range(31, 0), r1, r2, $urandom, $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mReg[i] = 32'd0;
      mKnown[i] = (i == 0);
    end
    mPc = RESET_PC;
    lastRes = 32'd0;
    reset = 1'b1;
    instr = 32'h0010_2023;   // sw x1,0(x0)
    readData = 32'd0;
    #3;
    checkVal("reset instrAddr", instrAddr, RESET_PC);
    checkVal("reset we", {31'd0, we}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Load / add / store
    exec(K_LW, 1, 0, 0, 32'd0, 32'h0000_00FF);  checkVal("lw result", lastRes, 32'd0);
    exec(K_ADD, 1, 1, 1, 32'd0, 32'd0);         checkVal("add result", lastRes, 32'h1FE);
    exec(K_SW, 0, 0, 1, 32'd0, 32'd0);
    // Branches: taken with equal zeros, not taken with x1 != x0
    exec(K_ADDI, 30, 0, 0, 32'd0, 32'd0);
    exec(K_ADDI, 31, 0, 0, 32'd0, 32'd0);
    exec(K_BEQ, 0, 30, 31, 32'd12, 32'd0);
    exec(K_BEQ, 0, 1, 0, 32'd8, 32'd0);
    exec(K_BNE, 0, 1, 0, 32'h1FF8, 32'd0);      // backward taken branch
    // Logic and compares
    exec(K_ADDI, 1, 0, 0, 32'd12, 32'd0);
    exec(K_ADDI, 2, 0, 0, 32'd10, 32'd0);
    exec(K_AND, 3, 1, 2, 32'd0, 32'd0);         checkVal("and result", lastRes, 32'd8);
    exec(K_OR, 3, 1, 2, 32'd0, 32'd0);          checkVal("or result", lastRes, 32'd14);
    exec(K_SLT, 3, 2, 1, 32'd0, 32'd0);         checkVal("slt lt", lastRes, 32'd1);
    exec(K_SLT, 3, 1, 2, 32'd0, 32'd0);         checkVal("slt gt", lastRes, 32'd0);
    exec(K_SLT, 3, 1, 1, 32'd0, 32'd0);         checkVal("slt eq", lastRes, 32'd0);
    exec(K_ADDI, 4, 0, 0, 32'hFF, 32'd0);
    exec(K_ADDI, 5, 0, 0, 32'h0F, 32'd0);
    exec(K_SUB, 3, 4, 5, 32'd0, 32'd0);         checkVal("sub result", lastRes, 32'hF0);
    exec(K_ADDI, 6, 0, 0, 32'hFFF, 32'd0);
    exec(K_SLT, 3, 6, 0, 32'd0, 32'd0);         checkVal("slt signed", lastRes, 32'd1);
    exec(K_SLTU, 3, 6, 0, 32'd0, 32'd0);        checkVal("sltu unsigned", lastRes, 32'd0);
    exec(K_ADDI, 8, 0, 0, 32'h400, 32'd0);      checkVal("addi bit30", lastRes, 32'h400);
    // Jumps
    exec(K_JAL, 1, 0, 0, 32'h200, 32'd0);       checkVal("jal result", lastRes, 32'h200);
    exec(K_JALR, 1, 1, 0, 32'h100, 32'd0);
    // Upper immediate and shifts
    exec(K_LUI, 1, 0, 0, 32'hABCDE, 32'd0);     checkVal("lui result", lastRes, 32'hABCD_E000);
    exec(K_ORI, 1, 1, 0, 32'h123, 32'd0);       checkVal("ori result", lastRes, 32'hABCD_E123);
    exec(K_ADDI, 2, 0, 0, 32'd8, 32'd0);
    exec(K_SRA, 3, 1, 2, 32'd0, 32'd0);         checkVal("sra result", lastRes, 32'hFFAB_CDE1);
    exec(K_SRL, 3, 1, 2, 32'd0, 32'd0);         checkVal("srl result", lastRes, 32'h00AB_CDE1);
    exec(K_SLL, 3, 1, 2, 32'd0, 32'd0);         checkVal("sll result", lastRes, 32'hCDE1_2300);
    // x0 destination and unsupported encodings leave registers untouched
    exec(K_ADDI, 0, 0, 0, 32'd5, 32'd0);
    exec(K_ADD, 3, 0, 0, 32'd0, 32'd0);         checkVal("x0 stays zero", lastRes, 32'd0);
    exec(K_ADDI, 7, 0, 0, 32'h55, 32'd0);
    exec(K_BADF7, 7, 1, 2, 32'd0, 32'd0);
    exec(K_BADOP, 0, 0, 0, 32'h0001_2380, 32'd0);
    exec(K_ADD, 3, 7, 0, 32'd0, 32'd0);         checkVal("bad funct no write", lastRes, 32'h55);
    // PC wrap-around at the top of the address space
    exec(K_ADDI, 9, 0, 0, 32'hFFC, 32'd0);
    exec(K_JALR, 0, 9, 0, 32'd0, 32'd0);
    exec(K_ADD, 3, 0, 0, 32'd0, 32'd0);
    exec(K_ADD, 3, 0, 0, 32'd0, 32'd0);

    randomRun(400);

    // Reset mid-run: PC clears at once, registers are kept, no write during reset
    exec(K_ADDI, 5, 0, 0, 32'h5A5, 32'd0);
    instr = 32'h0010_2023;
    #2;
    reset = 1'b1;
    #1;
    checkVal("async reset instrAddr", instrAddr, RESET_PC);
    checkVal("async reset we", {31'd0, we}, 32'd0);
    instr = 32'h1230_0293;   // addi x5,x0,0x123 presented while in reset
    @(negedge clk);
    checkVal("reset hold instrAddr", instrAddr, RESET_PC);
    reset = 1'b0;
    mPc = RESET_PC;
    exec(K_ADD, 6, 5, 0, 32'd0, 32'd0);         checkVal("x5 retained", lastRes, 32'h5A5);

    randomRun(100);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
